rx_req_splitter: RTL
====================

// Module: rx_req_splitter
// PURPOSE
//  Consumes scatter-gather elements (address/length) popped from the RX port's SG
//  element interface. Cuts each element into PCIe memory-read requests that respect
//  the max read request size and 4 KB boundaries, and allocates a tag per request.
//  Issues the requests on the RX_REQ handshake toward the TX engine. Sits directly
//  downstream of the RX port SG_ELEM_* outputs.
// PARAMETERS
//  C_MAX_READ_REQ  2  hard cap on request size: 0=128B,1=256B,2=512B,3=1KB,4=2KB,5=4KB
//  C_TAG_WIDTH     2  request tag width; 2**C_TAG_WIDTH tags can be outstanding
// PORTS
//  CLK                           in   1     clock
//  RST_N                         in   1     reset, asynchronous, active-low
//  CONFIG_MAX_READ_REQUEST_SIZE  in   3     PCIe max read request encoding (same as C_MAX_READ_REQ)
//  SG_ELEM_ADDR                  in   64    element byte address; bits[1:0] ignored
//  SG_ELEM_LEN                   in   32    element length in 32-bit words
//  SG_ELEM_RDY                   in   1     element valid at SG_ELEM_ADDR/LEN
//  SG_ELEM_REN                   out  1     pop strobe; element captured on the same cycle
//  RX_REQ                        out  1     read request valid
//  RX_REQ_ACK                    in   1     request accepted on this cycle
//  RX_REQ_TAG                    out  C_TAG_WIDTH  tag of the current request
//  RX_REQ_ADDR                   out  64    request byte address, dword aligned
//  RX_REQ_LEN                    out  10    request length in words; 0 encodes 1024
//  TAG_RELEASE                   in   1     completion for TAG_RELEASE_ID has fully arrived
//  TAG_RELEASE_ID                in   C_TAG_WIDTH  tag being released
//  ABORT                         in   1     drop the current element and any pending split
//  BUSY                          out  1     element in progress or tags outstanding
//  STAT_REQ_CNT                  out  32    accepted-request counter (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (RST_N=0, async): state=IDLE; SG_ELEM_REN=0; RX_REQ=0; RX_REQ_TAG=0;
//    RX_REQ_ADDR=0; RX_REQ_LEN=0; BUSY=0; STAT_REQ_CNT=0; all tags free.
//  - FSM states: IDLE, CALC, REQ, WAIT_TAG.
//  - IDLE: when SG_ELEM_RDY=1 and ABORT=0, assert SG_ELEM_REN for exactly 1 cycle.
//    Latch rAddr={ADDR[63:2],2'b00} and rRem=LEN, then go to CALC. rRem=0 returns to
//    IDLE with no request (the element is consumed).
//  - CALC (1 cycle): eff=min(CONFIG,C_MAX_READ_REQ); max_w=32<<eff;
//    bnd_w=(4096-rAddr[11:0])>>2; rLen=min(rRem,max_w,bnd_w). Compare in 32 bits.
//    Go to REQ if a tag is free, else to WAIT_TAG.
//  - WAIT_TAG: stay until any tag is free, then go to REQ.
//  - REQ: RX_REQ=1; RX_REQ_TAG=lowest free tag; ADDR/LEN stable until ACK.
//    On RX_REQ_ACK: mark the tag busy; rAddr+=rLen*4 (64-bit add, carry into upper
//    bits); rRem-=rLen; RX_REQ drops next cycle. Next state: CALC if rRem!=0, else IDLE.
//  - RX_REQ is never deasserted without ACK, except on ABORT or reset.
//  - RX_REQ_LEN=rLen[9:0], so 1024 words encodes as 0.
//  - Tag release: TAG_RELEASE frees TAG_RELEASE_ID the next cycle. If a release and an
//    ACK occur on the same cycle, both take effect. Releasing an already-free tag is a
//    no-op.
//  - ABORT (sync, level): from CALC/REQ/WAIT_TAG, go to IDLE next cycle; RX_REQ=0; rRem
//    cleared. Outstanding tags stay busy until released. ABORT has priority over ACK on
//    the same cycle (that request is not counted or tagged). IDLE does not pop while
//    ABORT=1.
//  - BUSY = (state!=IDLE) | (any tag busy).
//  - Throughput: at most one request per 2 cycles (CALC+REQ); latency from element pop
//    to RX_REQ is 2 cycles.
// CONFIGURATION
//  RX_REQ_SPLITTER_STATS_EN defined: STAT_REQ_CNT increments (wrapping at 2**32) on each
//    accepted RX_REQ_ACK not suppressed by ABORT; it clears only on reset.
//  Not defined: STAT_REQ_CNT is tied to 32'd0 and the counter is not synthesized.
// TESTING
//  1. CONFIG=2, ADDR=0x1000, LEN=300 -> 3 requests: len 128@0x1000, 128@0x1200,
//     44@0x1400; tags 0,1,2; then IDLE.
//  2. ADDR=0x0FF0, LEN=64, CONFIG=5, C_MAX_READ_REQ=2 -> 4@0x0FF0 (4K boundary),
//     then 60@0x1000.
//  3. LEN=0 element -> SG_ELEM_REN pulses once, no RX_REQ, BUSY back to 0 in 2 cycles.
//  4. C_MAX_READ_REQ=5, CONFIG=5, ADDR=0x2000, LEN=1024 -> one request, RX_REQ_LEN=0.
//  5. Hold TAG_RELEASE=0, LEN=1000, CONFIG=0 -> 4 requests issued, then WAIT_TAG.
//     Release tag 2 -> 5th request carries tag 2.
//  6. ABORT while RX_REQ=1 with ACK on the same cycle -> RX_REQ=0 next cycle, no tag
//     consumed, STAT_REQ_CNT unchanged. Also assert RST_N low mid-split -> all outputs
//     at reset values immediately.

Source files
------------

// File: rtl/rx_req_splitter_if.sv
// Handshake bundle between the SG element source, the request splitter and the TX engine.
// master = splitter side (pops elements, issues read requests); slave = environment side.
interface rx_req_splitter_if #(
   parameter int C_TAG_WIDTH = 2
);
   logic [63:0]            sg_elem_addr;
   logic [31:0]            sg_elem_len;
   logic                   sg_elem_rdy;
   logic                   sg_elem_ren;
   logic                   rx_req;
   logic                   rx_req_ack;
   logic [C_TAG_WIDTH-1:0] rx_req_tag;
   logic [63:0]            rx_req_addr;
   logic [9:0]             rx_req_len;

   modport master (
      input  sg_elem_addr, sg_elem_len, sg_elem_rdy, rx_req_ack,
      output sg_elem_ren, rx_req, rx_req_tag, rx_req_addr, rx_req_len
   );

   modport slave (
      output sg_elem_addr, sg_elem_len, sg_elem_rdy, rx_req_ack,
      input  sg_elem_ren, rx_req, rx_req_tag, rx_req_addr, rx_req_len
   );
endinterface

// File: rtl/rx_req_splitter.sv
// Splits SG elements into PCIe memory-read requests bounded by max read size and 4 KB pages.
// Optional request statistics counter enabled by defining RX_REQ_SPLITTER_STATS_EN.
//
// state    | meaning
// IDLE     | waiting for an SG element to pop
// CALC     | computing the length of the next request
// REQ      | request presented, waiting for ack
// WAIT_TAG | request length known, all tags outstanding
module rx_req_splitter #(
   parameter int C_MAX_READ_REQ = 2,
   parameter int C_TAG_WIDTH    = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [2:0]             config_max_read_request_size_i,
   input  logic                   tag_release_i,
   input  logic [C_TAG_WIDTH-1:0] tag_release_id_i,
   input  logic                   abort_i,
   output logic                   busy_o,
   output logic [31:0]            stat_req_cnt_o,
   rx_req_splitter_if.master      bus
);
   localparam int          NTAG    = 1 << C_TAG_WIDTH;
   localparam logic [2:0]  MAX_ENC = 3'(C_MAX_READ_REQ);

   typedef enum logic [1:0] {IDLE, CALC, REQ, WAIT_TAG} state_t;

   state_t                 state_q;
   logic [63:0]            addr_q;
   logic [31:0]            rem_q;
   logic [31:0]            rlen_q;
   logic                   rx_req_q;
   logic [C_TAG_WIDTH-1:0] tag_q;
   logic [NTAG-1:0]        tag_busy_q;
   logic [NTAG-1:0]        tag_busy_d;

   logic [2:0]             eff;
   logic [31:0]            max_w;
   logic [31:0]            bnd_w;
   logic [31:0]            rlen_d;
   logic [C_TAG_WIDTH-1:0] free_tag;
   logic                   any_free;
   logic                   pop;
   logic                   acc;

   always_comb begin
      eff    = (config_max_read_request_size_i > MAX_ENC) ? MAX_ENC : config_max_read_request_size_i;
      max_w  = 32'd32 << eff;
      bnd_w  = (32'd4096 - {20'd0, addr_q[11:0]}) >> 2;
      rlen_d = rem_q;
      if (max_w < rlen_d) rlen_d = max_w;
      if (bnd_w < rlen_d) rlen_d = bnd_w;
   end

   always_comb begin
      free_tag = '0;
      for (int i = NTAG - 1; i >= 0; i--) begin
         if (!tag_busy_q[i]) free_tag = C_TAG_WIDTH'(i);
      end
      any_free = ~&tag_busy_q;
   end

   // Pop is combinational so the element is captured in the same cycle it is popped;
   // gating with rst_n keeps the strobe low while the block is held in reset.
   assign pop = rst_n && (state_q == IDLE) && bus.sg_elem_rdy && !abort_i;
   assign acc = (state_q == REQ) && bus.rx_req_ack && !abort_i;

   always_comb begin
      tag_busy_d = tag_busy_q;
      if (tag_release_i) tag_busy_d[tag_release_id_i] = 1'b0;
      if (acc)           tag_busy_d[tag_q]            = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         rem_q      <= '0;
         rlen_q     <= '0;
         rx_req_q   <= 1'b0;
         tag_q      <= '0;
         tag_busy_q <= '0;
      end else begin
         tag_busy_q <= tag_busy_d;
         case (state_q)
            IDLE: begin
               if (pop) begin
                  addr_q <= bus.sg_elem_addr & ~64'h3;
                  rem_q  <= bus.sg_elem_len;
                  if (bus.sg_elem_len != 32'd0) state_q <= CALC;
               end
            end
            CALC: begin
               if (abort_i) begin
                  state_q <= IDLE;
                  rem_q   <= '0;
               end else begin
                  rlen_q <= rlen_d;
                  if (any_free) begin
                     state_q  <= REQ;
                     rx_req_q <= 1'b1;
                     tag_q    <= free_tag;
                  end else begin
                     state_q <= WAIT_TAG;
                  end
               end
            end
            WAIT_TAG: begin
               if (abort_i) begin
                  state_q <= IDLE;
                  rem_q   <= '0;
               end else if (any_free) begin
                  state_q  <= REQ;
                  rx_req_q <= 1'b1;
                  tag_q    <= free_tag;
               end
            end
            REQ: begin
               if (abort_i) begin
                  state_q  <= IDLE;
                  rx_req_q <= 1'b0;
                  rem_q    <= '0;
               end else if (bus.rx_req_ack) begin
                  rx_req_q <= 1'b0;
                  addr_q   <= addr_q + {30'd0, rlen_q, 2'b00};
                  rem_q    <= rem_q - rlen_q;
                  state_q  <= (rem_q != rlen_q) ? CALC : IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef RX_REQ_SPLITTER_STATS_EN
   logic [31:0] stat_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   stat_q <= '0;
      else if (acc) stat_q <= stat_q + 32'd1;
   end

   assign stat_req_cnt_o = stat_q;
`else
   assign stat_req_cnt_o = 32'd0;
`endif

   assign bus.sg_elem_ren = pop;
   assign bus.rx_req      = rx_req_q;
   assign bus.rx_req_tag  = tag_q;
   assign bus.rx_req_addr = addr_q;
   assign bus.rx_req_len  = rlen_q[9:0];
   assign busy_o          = (state_q != IDLE) | (|tag_busy_q);
endmodule
